uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver for the serial front end. It supports configurable data width, runtime parity mode, 1 or 2 stop bits and configurable oversampling. Each bit is resolved by a 3-sample majority vote. It rejects false starts and reports parity, framing and break errors. It runs from the system clock with the shared baud-rate generator's oversampling tick and feeds the same byte-consumer interface as the existing receive path.

Parameters:
DBIT, 8, data bits per frame; legal 5..9; LSB received first
OVS, 16, baud ticks per bit period; legal even values >= 8
STOP_BITS, 1, stop bits checked per frame; legal 1 or 2

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_rx  input  1  asynchronous serial line, idle high
i_s_tick  input  1  one-cycle oversampling tick from baud generator, OVS per bit
i_par_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; latched at start detection
o_rx_done_tick  output  1  one-cycle pulse; o_dout and error flags are valid with it
o_dout  output  DBIT  last received word, held until next done
o_parity_err  output  1  parity mismatch in last frame, held until next done
o_frame_err  output  1  any stop-bit sample resolved 0 in last frame, held
o_break  output  1  last frame all-zero incl. parity and stop bits, held

Behaviour:
- Reset is synchronous and active-high on i_clk; all state is registered on i_clk.
- Reset values: all outputs 0, state IDLE, counters 0, synchroniser flops 1.
- Reset mid-frame aborts the frame. No done pulse is produced.
- i_rx passes through a 2-flop synchroniser before any use, adding 2 cycles of latency. All references to rx below mean the synchronised value.
- Majority vote: samples are taken on ticks where s = OVS-3, OVS-2 and OVS-1. The bit is resolved at s = OVS-1 as the majority of the 3 samples.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - rx = 0 -> START, s = 0, latch i_par_mode.
  - Ticks are ignored in IDLE, including a tick coincident with the edge.
- START:
  - Count ticks. At s = OVS/2-1 (start-bit midpoint), if rx = 1 it is a false start: go to IDLE with no pulse.
  - Otherwise go to DATA with s = 0, n = 0.
- DATA:
  - Each bit lasts OVS ticks measured from the midpoint.
  - At resolution, shift the bit into the MSB of the DBIT shift register and clear s.
  - When n = DBIT-1, go to PARITY if the latched mode is even or odd, else go to STOP. Otherwise n++.
- PARITY:
  - Resolve one bit the same way.
  - Even mode: error if XOR(data, parity bit) = 1. Odd mode: error if it = 0.
  - Then go to STOP.
- STOP:
  - Resolve STOP_BITS bits. Any bit resolved 0 sets the frame error.
  - At resolution of the last stop bit (its midpoint), drive the outputs:
    - o_rx_done_tick = 1 for exactly one cycle.
    - o_dout, o_parity_err, o_frame_err and o_break update in that same cycle.
  - No error -> IDLE, which allows back-to-back frames with no gap.
  - Frame error -> WAIT_HIGH.
- WAIT_HIGH: stay until rx = 1, then go to IDLE. A held-low break line therefore yields exactly one done pulse.
- Break condition: data = 0, parity bit = 0 when enabled, and all stop bits = 0. o_break = 1 implies o_frame_err = 1.
- Latency: done pulse occurs (OVS/2) + (DBIT + P + STOP_BITS - 1)·OVS + OVS ticks after start detection, where P = 1 if parity is enabled. Add the 2-cycle synchroniser delay to the falling edge.
- Counter widths: s is clog2(OVS) bits; n is clog2(DBIT) bits. No wrap occurs within legal parameters.
- A change on i_par_mode mid-frame has no effect on the current frame.

Decomposition:
- Package uart_pkg:
  - State encoding localparams.
  - Parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - Legal-range checks for DBIT, OVS and STOP_BITS as elaboration-time assertions.
- One natural sub-module, uart_bit_sampler: the 2-flop synchroniser plus the 3-sample majority register. Inputs are clk, reset, rx, tick and s; outputs are rx_sync and bit_value.

Test Plan:
- 8N1, OVS=16, frame 0xA5 -> one o_rx_done_tick, o_dout=0xA5, all errors 0. Done occurs 152 ticks after start detection.
- Even parity, 0x07 with parity bit 1 -> parity_err=0. Same frame with parity bit 0 -> parity_err=1, o_dout=0x07. Odd mode with bit 0 -> no error.
- Low glitch of 3 ticks on an idle line -> no done pulse, FSM returns to IDLE. A following valid 0x3C frame is received correctly.
- One-tick inverted glitch at s=OVS-2 inside data bit 3 of 0x55 -> majority corrects, o_dout=0x55. Two-tick glitch -> bit flipped, o_dout=0x5D.
- Stop bit driven 0 on 0x81 -> frame_err=1, break=0. Line held low for 20 bit times -> break=1 and frame_err=1, exactly one done pulse, next frame accepted only after line returns high.
- i_reset asserted after 4 data bits -> outputs 0, no pulse. Then frames 0x55 and 0xAA sent back-to-back with STOP_BITS=2 -> two pulses with correct data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, parity modes and configuration checks for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic bit dbit_legal(input int d);
        return (d >= 5) && (d <= 9);
    endfunction

    function automatic bit ovs_legal(input int o);
        return (o >= 8) && ((o % 2) == 0);
    endfunction

    function automatic bit stop_bits_legal(input int s);
        return (s == 1) || (s == 2);
    endfunction

    // Mode 11 behaves as "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop line synchroniser plus the three-sample majority vote used to resolve each bit.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVS = 16,
    parameter int SW  = $clog2(OVS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic          tick,
    input  logic [SW-1:0] s,
    output logic          rx_sync,
    output logic          bit_value
);

    localparam logic [SW-1:0] S_SAMP_A = SW'(OVS - 3);
    localparam logic [SW-1:0] S_SAMP_B = SW'(OVS - 2);

    logic rx_meta_p0;
    logic rx_sync_p1;
    logic samp_a;
    logic samp_b;

    // Stage p0 -> p1: synchroniser; the first two votes are captured from p1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_sync_p1 <= rx_meta_p0;
            if (tick && (s == S_SAMP_A)) samp_a <= rx_sync_p1;
            if (tick && (s == S_SAMP_B)) samp_b <= rx_sync_p1;
        end
    end

    assign rx_sync   = rx_sync_p1;
    // Third vote is the live sample taken on the resolving tick.
    assign bit_value = majority3(samp_a, samp_b, rx_sync_p1);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DBIT data bits, runtime parity, STOP_BITS stop bits,
// OVS-times oversampling with majority-voted bits and parity/framing/break reporting.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int OVS       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    input  logic [1:0]      i_par_mode,
    output logic            o_rx_done_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_break
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID     = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    if (!dbit_legal(DBIT)) begin : g_bad_dbit
        $error("uart_rx_cfg: DBIT must be in 5..9");
    end
    if (!ovs_legal(OVS)) begin : g_bad_ovs
        $error("uart_rx_cfg: OVS must be even and >= 8");
    end
    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    logic rx_sync;
    logic bit_value;

    state_t          state_q,    state_d;
    logic [SW-1:0]   s_q,        s_d;
    logic [NW-1:0]   n_q,        n_d;
    logic [DBIT-1:0] shift_q,    shift_d;
    logic [1:0]      mode_q,     mode_d;
    logic            pbit_q,     pbit_d;
    logic            perr_q,     perr_d;
    logic            ferr_q,     ferr_d;
    logic            stop_one_q, stop_one_d;
    logic            done_q,     done_d;
    logic [DBIT-1:0] dout_q,     dout_d;
    logic            perr_out_q, perr_out_d;
    logic            ferr_out_q, ferr_out_d;
    logic            brk_q,      brk_d;
    logic            ferr_now;
    logic            stop_one_now;

    uart_bit_sampler #(
        .OVS (OVS),
        .SW  (SW)
    ) u_sampler (
        .clk       (i_clk),
        .reset     (i_reset),
        .rx        (i_rx),
        .tick      (i_s_tick),
        .s         (s_q),
        .rx_sync   (rx_sync),
        .bit_value (bit_value)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            n_q        <= '0;
            shift_q    <= '0;
            mode_q     <= PAR_NONE;
            pbit_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
            done_q     <= 1'b0;
            dout_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            pbit_q     <= pbit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_one_q <= stop_one_d;
            done_q     <= done_d;
            dout_q     <= dout_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        pbit_d       = pbit_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        stop_one_d   = stop_one_q;
        done_d       = 1'b0;
        dout_d       = dout_q;
        perr_out_d   = perr_out_q;
        ferr_out_d   = ferr_out_q;
        brk_d        = brk_q;
        ferr_now     = ferr_q | ~bit_value;
        stop_one_now = stop_one_q | bit_value;

        case (state_q)
            ST_IDLE: begin
                // Ticks are deliberately ignored here; the count starts from the edge.
                if (!rx_sync) begin
                    state_d    = ST_START;
                    s_d        = '0;
                    mode_d     = i_par_mode;
                    pbit_d     = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop_one_d = 1'b0;
                end
            end

            ST_START: begin
                if (i_s_tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shift_d = {bit_value, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            n_d     = '0;
                            state_d = par_enabled(mode_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (i_s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        pbit_d  = bit_value;
                        perr_d  = (mode_q == PAR_EVEN) ? (^shift_q ^ bit_value)
                                                       : ~(^shift_q ^ bit_value);
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (i_s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (n_q == STOP_LAST) begin
                            n_d        = '0;
                            done_d     = 1'b1;
                            dout_d     = shift_q;
                            perr_out_d = perr_q;
                            ferr_out_d = ferr_now;
                            brk_d      = (shift_q == '0) && !pbit_q && !stop_one_now;
                            state_d    = ferr_now ? ST_WAIT_HIGH : ST_IDLE;
                        end else begin
                            n_d        = n_q + NW'(1);
                            ferr_d     = ferr_now;
                            stop_one_d = stop_one_now;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            ST_WAIT_HIGH: begin
                // A held-low line must go idle before another start is accepted.
                if (rx_sync) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_rx_done_tick = done_q;
    assign o_dout         = dout_q;
    assign o_parity_err   = perr_out_q;
    assign o_frame_err    = ferr_out_q;
    assign o_break        = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: one 8-bit/1-stop instance and one 8-bit/2-stop instance.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] par_mode = 2'b00;
    logic [1:0] div = 2'b00;
    int         tick_cnt = 0;

    logic       done1, perr1, ferr1, brk1;
    logic [7:0] dout1;
    logic       done2, perr2, ferr2, brk2;
    logic [7:0] dout2;

    int checks = 0;
    int errors = 0;

    int         n_done1 = 0;
    int         n_done2 = 0;
    int         done1_at = 0;
    int         start_tick = 0;
    logic [7:0] d1_q = 8'h00;
    logic       p1_q = 1'b0, f1_q = 1'b0, b1_q = 1'b0;
    logic [7:0] d2_log [0:3];

    uart_rx_cfg #(.DBIT(8), .OVS(16), .STOP_BITS(1)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx           (rx),
        .i_s_tick       (tick),
        .i_par_mode     (par_mode),
        .o_rx_done_tick (done1),
        .o_dout         (dout1),
        .o_parity_err   (perr1),
        .o_frame_err    (ferr1),
        .o_break        (brk1)
    );

    uart_rx_cfg #(.DBIT(8), .OVS(16), .STOP_BITS(2)) dut2 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx           (rx2),
        .i_s_tick       (tick),
        .i_par_mode     (par_mode),
        .o_rx_done_tick (done2),
        .o_dout         (dout2),
        .o_parity_err   (perr2),
        .o_frame_err    (ferr2),
        .o_break        (brk2)
    );

    always #5 clk = ~clk;

    // One tick every four clocks.
    always @(posedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd3);
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            n_done1  <= n_done1 + 1;
            done1_at <= tick_cnt;
            d1_q     <= dout1;
            p1_q     <= perr1;
            f1_q     <= ferr1;
            b1_q     <= brk1;
        end
        if (done2 === 1'b1) begin
            n_done2 <= n_done2 + 1;
            d2_log[n_done2 % 4] <= dout2;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    // Caller must be just past a tick edge; each frame bit is held for 16 ticks.
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                              input logic pbit, input int nstop, input logic sval,
                              input int gidx, input int gstart, input int glen,
                              input logic [1:0] mid_mode);
        logic seq [0:11];
        int   nb;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i] = data[i];
        nb = 9;
        if (par_en) begin
            seq[nb] = pbit;
            nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            seq[nb] = sval;
            nb++;
        end
        start_tick = tick_cnt;
        for (int i = 0; i < nb; i++) begin
            for (int t = 0; t < 16; t++) begin
                logic v;
                v = seq[i];
                if (i == gidx && t >= gstart && t < gstart + glen) v = ~v;
                if (i == 1 && t == 0) par_mode = mid_mode;
                if (sel) rx2 = v; else rx = v;
                wait_tick();
            end
        end
        if (sel) rx2 = 1'b1; else rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({done1, dout1, perr1, ferr1, brk1} !== 12'h000) begin
            $display("FAIL reset_dut1: got %h expected 000", {done1, dout1, perr1, ferr1, brk1});
            errors++;
        end
        checks++;
        if ({done2, dout2, perr2, ferr2, brk2} !== 12'h000) begin
            $display("FAIL reset_dut2: got %h expected 000", {done2, dout2, perr2, ferr2, brk2});
            errors++;
        end
        wait_ticks(4);
    endtask

    task automatic test_basic();
        int c0;
        c0 = n_done1;
        par_mode = 2'b00;
        send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1, -1, 0, 0, 2'b00);
        checks++;
        if (n_done1 - c0 !== 1) begin
            $display("FAIL basic_pulses: got %0d expected 1", n_done1 - c0);
            errors++;
        end
        checks++;
        if (d1_q !== 8'hA5) begin
            $display("FAIL basic_dout: got %h expected a5", d1_q);
            errors++;
        end
        checks++;
        if ({p1_q, f1_q, b1_q} !== 3'b000) begin
            $display("FAIL basic_flags: got %b expected 000", {p1_q, f1_q, b1_q});
            errors++;
        end
        checks++;
        if (done1_at - start_tick !== 152) begin
            $display("FAIL basic_latency: got %0d expected 152", done1_at - start_tick);
            errors++;
        end
    endtask

    task automatic test_parity();
        par_mode = 2'b01;
        send_frame(0, 8'h07, 1, 1'b1, 1, 1'b1, -1, 0, 0, 2'b01);
        checks++;
        if ({d1_q, p1_q, f1_q} !== {8'h07, 2'b00}) begin
            $display("FAIL even_ok: got dout=%h perr=%b ferr=%b expected 07 0 0", d1_q, p1_q, f1_q);
            errors++;
        end
        checks++;
        if (done1_at - start_tick !== 168) begin
            $display("FAIL parity_latency: got %0d expected 168", done1_at - start_tick);
            errors++;
        end
        send_frame(0, 8'h07, 1, 1'b0, 1, 1'b1, -1, 0, 0, 2'b01);
        checks++;
        if ({d1_q, p1_q, f1_q} !== {8'h07, 2'b10}) begin
            $display("FAIL even_bad: got dout=%h perr=%b ferr=%b expected 07 1 0", d1_q, p1_q, f1_q);
            errors++;
        end
        // Mode switched to none once the frame is under way; the latched odd mode must hold.
        par_mode = 2'b10;
        send_frame(0, 8'h07, 1, 1'b0, 1, 1'b1, -1, 0, 0, 2'b00);
        checks++;
        if ({d1_q, p1_q, f1_q} !== {8'h07, 2'b00}) begin
            $display("FAIL odd_ok: got dout=%h perr=%b ferr=%b expected 07 0 0", d1_q, p1_q, f1_q);
            errors++;
        end
        par_mode = 2'b00;
    endtask

    task automatic test_false_start();
        int c0;
        c0 = n_done1;
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(20);
        checks++;
        if (n_done1 !== c0) begin
            $display("FAIL false_start_pulse: got %0d expected %0d", n_done1, c0);
            errors++;
        end
        send_frame(0, 8'h3C, 0, 1'b0, 1, 1'b1, -1, 0, 0, 2'b00);
        checks++;
        if ({n_done1 - c0, d1_q} !== {32'd1, 8'h3C}) begin
            $display("FAIL after_glitch: got pulses=%0d dout=%h expected 1 3c", n_done1 - c0, d1_q);
            errors++;
        end
    endtask

    task automatic test_majority();
        send_frame(0, 8'h55, 0, 1'b0, 1, 1'b1, 4, 6, 1, 2'b00);
        checks++;
        if (d1_q !== 8'h55) begin
            $display("FAIL vote_one_tick: got %h expected 55", d1_q);
            errors++;
        end
        send_frame(0, 8'h55, 0, 1'b0, 1, 1'b1, 4, 6, 2, 2'b00);
        checks++;
        if (d1_q !== 8'h5D) begin
            $display("FAIL vote_two_tick: got %h expected 5d", d1_q);
            errors++;
        end
    endtask

    task automatic test_frame_break();
        int c0;
        send_frame(0, 8'h81, 0, 1'b0, 1, 1'b0, -1, 0, 0, 2'b00);
        checks++;
        if ({d1_q, f1_q, b1_q} !== {8'h81, 2'b10}) begin
            $display("FAIL stop_low: got dout=%h ferr=%b brk=%b expected 81 1 0", d1_q, f1_q, b1_q);
            errors++;
        end
        wait_ticks(4);
        c0 = n_done1;
        rx = 1'b0;
        wait_ticks(320);
        checks++;
        if (n_done1 - c0 !== 1) begin
            $display("FAIL break_pulses: got %0d expected 1", n_done1 - c0);
            errors++;
        end
        checks++;
        if ({d1_q, p1_q, f1_q, b1_q} !== {8'h00, 3'b011}) begin
            $display("FAIL break_flags: got dout=%h perr=%b ferr=%b brk=%b expected 00 0 1 1",
                     d1_q, p1_q, f1_q, b1_q);
            errors++;
        end
        rx = 1'b1;
        wait_ticks(4);
        send_frame(0, 8'h96, 0, 1'b0, 1, 1'b1, -1, 0, 0, 2'b00);
        checks++;
        if ({n_done1 - c0, d1_q, f1_q, b1_q} !== {32'd2, 8'h96, 2'b00}) begin
            $display("FAIL after_break: got pulses=%0d dout=%h ferr=%b brk=%b expected 2 96 0 0",
                     n_done1 - c0, d1_q, f1_q, b1_q);
            errors++;
        end
    endtask

    task automatic test_reset_midframe();
        int c0;
        logic [3:0] lo;
        c0 = n_done1;
        lo = 4'h5;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = lo[i];
            wait_ticks(16);
        end
        reset = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({done1, dout1, perr1, ferr1, brk1} !== 12'h000) begin
            $display("FAIL midframe_reset_out: got %h expected 000", {done1, dout1, perr1, ferr1, brk1});
            errors++;
        end
        wait_ticks(200);
        checks++;
        if (n_done1 !== c0) begin
            $display("FAIL midframe_reset_pulse: got %0d expected %0d", n_done1, c0);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = n_done2;
        send_frame(1, 8'h55, 0, 1'b0, 2, 1'b1, -1, 0, 0, 2'b00);
        send_frame(1, 8'hAA, 0, 1'b0, 2, 1'b1, -1, 0, 0, 2'b00);
        wait_ticks(2);
        checks++;
        if (n_done2 - c0 !== 2) begin
            $display("FAIL b2b_pulses: got %0d expected 2", n_done2 - c0);
            errors++;
        end
        checks++;
        if ({d2_log[c0 % 4], d2_log[(c0 + 1) % 4]} !== 16'h55AA) begin
            $display("FAIL b2b_data: got %h %h expected 55 aa", d2_log[c0 % 4], d2_log[(c0 + 1) % 4]);
            errors++;
        end
        checks++;
        if ({perr2, ferr2, brk2} !== 3'b000) begin
            $display("FAIL b2b_flags: got %b expected 000", {perr2, ferr2, brk2});
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_majority();
        test_frame_break();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
